// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder controller.
package serial_adder_pkg;

    localparam int unsigned SERIAL_ADD_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder built from two half-adder stages and an OR.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic hs1, hc1, hc2;

    assign hs1 = a ^ b;
    assign hc1 = a & b;
    assign s   = hs1 ^ cin;
    assign hc2 = hs1 & cin;
    assign co  = hc1 | hc2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add (LSB first) over WIDTH cycles with a start/busy/done handshake.
// Define SERIAL_ADD_SUB_EN to add the sub port (A - B as A + ~B + 1).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned KW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sw_q, sw_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [KW-1:0]    k_q, k_d;
    logic             c_q, c_d, cout_q, cout_d;
    logic             fa_b, fa_s, fa_co;

`ifdef SERIAL_ADD_SUB_EN
    logic sub_q, sub_d;
    assign fa_b = sb_q[0] ^ sub_q;
`else
    assign fa_b = sb_q[0];
`endif

    serial_fa_cell u_cell (
        .a   (sa_q[0]),
        .b   (fa_b),
        .cin (c_q),
        .s   (fa_s),
        .co  (fa_co)
    );

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sw_d    = sw_q;
        c_d     = c_q;
        k_d     = k_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
`ifdef SERIAL_ADD_SUB_EN
                    sub_d   = sub;
                    c_d     = sub;
`else
                    c_d     = 1'b0;
`endif
                    k_d     = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sw_d = {fa_s, sw_q[WIDTH-1:1]};
                sa_d = sa_q >> 1;
                sb_d = sb_q >> 1;
                c_d  = fa_co;
                k_d  = k_q + KW'(1);
                // Last bit: publish the completed word and its carry together.
                if (k_q == KW'(WIDTH - 1)) begin
                    sum_d   = sw_d;
                    cout_d  = fa_co;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sa_q    <= '0;
            sb_q    <= '0;
            sw_q    <= '0;
            c_q     <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sw_q    <= sw_d;
            c_q     <= c_d;
            k_q     <= k_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADD_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8).
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         sub;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int checks = 0;
    int errors = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start one operation and follow it through RUN and DONE, cycle by cycle.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic sv, input logic [W-1:0] es, input logic ec,
                          input logic [W-1:0] prev);
        start = 1'b1; a = av; b = bv; sub = sv;
        tick();
        start = 1'b0; a = ~av; b = ~bv; sub = ~sv;
        for (int i = 0; i < int'(W); i++) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_nodone"}, 32'(done), 32'd0);
            chk({tag, "_hold"}, 32'(sum), 32'(prev));
            tick();
        end
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        tick();
        chk({tag, "_done_clr"}, 32'(done), 32'd0);
    endtask

    int          dcnt;
    logic [W-1:0] dsum;

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        tick();

        run_op("add3_5", 8'd3, 8'd5, 1'b0, 8'h08, 1'b0, 8'h00);
        run_op("ovf", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h08);

        // start re-asserted at E3 while busy must be dropped
        start = 1'b1; a = 8'd10; b = 8'd20;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1; a = 8'd1; b = 8'd1;
        tick();
        start = 1'b0;
        dcnt = 0; dsum = '0;
        for (int i = 0; i < 6; i++) begin
            if (done) begin
                dcnt++;
                dsum = sum;
            end
            tick();
        end
        chk("ign_done_cnt", 32'(dcnt), 32'd1);
        chk("ign_sum", 32'(dsum), 32'd30);
        chk("ign_idle", 32'(busy), 32'd0);
        run_op("after_ign", 8'd1, 8'd1, 1'b0, 8'd2, 1'b0, 8'd30);

        // asynchronous reset just after E4 of 100+100
        start = 1'b1; a = 8'd100; b = 8'd100;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_sum", 32'(sum), 32'd0);
        chk("arst_cout", 32'(cout), 32'd0);
        tick();
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < int'(W) + 4; i++) begin
            if (done || busy) dcnt++;
            tick();
        end
        chk("arst_quiet", 32'(dcnt), 32'd0);
        run_op("after_rst", 8'd7, 8'd9, 1'b0, 8'd16, 1'b0, 8'd0);

`ifdef SERIAL_ADD_SUB_EN
        run_op("sub5_3", 8'd5, 8'd3, 1'b1, 8'h02, 1'b1, 8'd16);
        run_op("sub3_5", 8'd3, 8'd5, 1'b1, 8'hFE, 1'b0, 8'h02);
`endif

        // start held high: done at t=9,19,29,39 after raising start
        start = 1'b1; a = 8'd4; b = 8'd6; sub = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            chk("b2b_done", 32'(done), 32'((t >= 9) && ((t - 9) % 10 == 0)));
            if (done) chk("b2b_sum", 32'(sum), 32'd10);
        end
        start = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
